// File: rtl/fp_pkg.sv
// Shared float-to-fixed definitions: field layout, FSM states, saturation values.
// No logic; constants, types and a field-extract helper only.
// Imported by the classifier and the converter top.
package fp_pkg;

    localparam int BIAS   = 127;
    localparam int MANT_W = 23;
    localparam int EXP_W  = 8;

    localparam logic [31:0] POS_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_fields_t;

    function automatic fp_fields_t split_float(input logic [31:0] f);
        fp_fields_t r;
        r.sign = f[31];
        r.exp  = f[30:23];
        r.mant = f[22:0];
        return r;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Decodes a float plus binary-point position into leading-one position and special cases.
// Combinational, zero latency.
// No handshake; consumed by float_to_fixed at accept.
module fp_classify
    import fp_pkg::*;
(
    input  logic              [31:0] float_in,
    input  logic              [4:0]  fixpointpos,
    output logic                     is_zero,
    output logic                     is_special,
    output logic signed       [9:0]  p,
    output logic signed       [9:0]  s,
    output logic                     sat,
    output logic                     unf
);

    fp_fields_t        fin;
    logic signed [9:0] exp_s;
    logic signed [9:0] pos_s;

    assign fin   = split_float(float_in);
    assign exp_s = {2'b00, fin.exp};
    assign pos_s = {5'b00000, fixpointpos};

    assign is_zero    = (fin.exp == '0);
    assign is_special = (fin.exp == '1);
    assign p          = exp_s - 10'(BIAS) + pos_s;
    assign s          = p - 10'(MANT_W);

    // Leading one at bit 31 only fits as exactly -2^31.
    assign sat = is_special ||
                 (!is_zero && ((p > 10'sd31) ||
                               ((p == 10'sd31) && !(fin.sign && (fin.mant == '0)))));
    assign unf = !is_zero && !is_special && p[9];

endmodule

// File: rtl/float_to_fixed.sv
// IEEE-754 single to 32-bit two's-complement fixed point with run-time binary point.
// Latency 1 + ceil(|s|/SHIFT_STEP) cycles from accept; one operand in flight.
// Result held in DONE until out_ready; in_ready only in IDLE.
module float_to_fixed
    import fp_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] float_in,
    input  logic [4:0]  fixpointpos,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fixed_out,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    state_t            state, state_nxt;
    fp_fields_t        fin;
    logic              is_zero, is_special, sat, unf;
    logic signed [9:0] p, s;

    logic        sign_q;
    logic        left_q;
    logic [31:0] mag_q;
    logic [4:0]  cnt_q;

    logic        accept;
    logic        direct;
    logic [31:0] mag_in;
    logic [31:0] sat_val;
    logic [31:0] mag_shift;
    logic [4:0]  k;
    logic [4:0]  cnt_rem;

    fp_classify u_classify (
        .float_in    (float_in),
        .fixpointpos (fixpointpos),
        .is_zero     (is_zero),
        .is_special  (is_special),
        .p           (p),
        .s           (s),
        .sat         (sat),
        .unf         (unf)
    );

    assign fin     = split_float(float_in);
    assign accept  = in_valid && in_ready;
    assign mag_in  = {8'h00, 1'b1, fin.mant};
    // Leading one already at bit MANT_W means no shift is needed.
    assign direct  = sat || unf || is_zero || (p == 10'(MANT_W));
    assign sat_val = (fin.sign && !(is_special && (fin.mant != '0))) ? NEG_MIN : POS_MAX;

    always_comb begin
        k         = (cnt_q < STEP) ? cnt_q : STEP;
        mag_shift = left_q ? (mag_q << k) : (mag_q >> k);
        cnt_rem   = cnt_q - k;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = direct ? DONE : SHIFT;
            SHIFT:   if (cnt_rem == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_q    <= 1'b0;
            left_q    <= 1'b0;
            mag_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            fixed_out <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q <= fin.sign;
                        mag_q  <= mag_in;
                        left_q <= !s[9];
                        cnt_q  <= s[9] ? 5'(-s) : 5'(s);
                        if (direct) begin
                            out_valid <= 1'b1;
                            overflow  <= sat;
                            underflow <= unf;
                            if (sat)                fixed_out <= sat_val;
                            else if (unf || is_zero) fixed_out <= '0;
                            else                    fixed_out <= fin.sign ? -mag_in : mag_in;
                        end
                    end
                end
                SHIFT: begin
                    mag_q <= mag_shift;
                    cnt_q <= cnt_rem;
                    if (cnt_rem == '0) begin
                        out_valid <= 1'b1;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        fixed_out <= sign_q ? -mag_shift : mag_shift;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_fixed.sv
// Drives a SHIFT_STEP=1 and a SHIFT_STEP=4 converter in lockstep and compares
// results, flags and latency against an arithmetic reference model.
module tb_float_to_fixed;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] float_in = '0;
    logic [4:0]  fixpointpos = '0;
    logic        out_ready = 1'b0;

    logic        rdy1, vld1, of1, uf1;
    logic [31:0] fo1;
    logic        rdy4, vld4, of4, uf4;
    logic [31:0] fo4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    float_to_fixed #(.SHIFT_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .float_in(float_in), .fixpointpos(fixpointpos),
        .out_valid(vld1), .out_ready(out_ready), .fixed_out(fo1),
        .overflow(of1), .underflow(uf1)
    );

    float_to_fixed #(.SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .float_in(float_in), .fixpointpos(fixpointpos),
        .out_valid(vld4), .out_ready(out_ready), .fixed_out(fo4),
        .overflow(of4), .underflow(uf4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Value = 1.mant * 2^(exp-127) * 2^fixpointpos, truncated toward zero,
    // saturated when it does not fit in signed 32 bits.
    task automatic model(input logic [31:0] f, input logic [4:0] fp,
                         output logic [31:0] val, output logic ov, output logic un,
                         output bit resolved, output int shift_abs);
        int     e, pos, sh;
        longint mag, m;
        bit     sgn;
        sgn = f[31];
        e   = int'(f[30:23]);
        val = 32'd0; ov = 1'b0; un = 1'b0; resolved = 1'b1; shift_abs = 0;
        if (e == 0) begin
            val = 32'd0;
        end else if (e == 255) begin
            ov  = 1'b1;
            val = (f[22:0] != 0 || !sgn) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else begin
            pos = e - 127 + int'(fp);
            if (pos < 0) begin
                un = 1'b1;
            end else if (pos > 31) begin
                ov  = 1'b1;
                val = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                mag = longint'({1'b1, f[22:0]});
                sh  = pos - 23;
                m   = (sh >= 0) ? (mag << sh) : (mag >> (-sh));
                if (!sgn && m > 64'sd2147483647) begin
                    ov = 1'b1; val = 32'h7FFF_FFFF;
                end else if (sgn && m > 64'sd2147483648) begin
                    ov = 1'b1; val = 32'h8000_0000;
                end else begin
                    val       = sgn ? 32'(-m) : 32'(m);
                    resolved  = 1'b0;
                    shift_abs = (sh < 0) ? -sh : sh;
                end
            end
        end
    endtask

    function automatic int lat_for(input bit resolved, input int shift_abs, input int step);
        if (resolved) return 1;
        return 1 + (shift_abs + step - 1) / step;
    endfunction

    task automatic run_op(input logic [31:0] f, input logic [4:0] fp,
                          input bit hold_ready, input int bp_cycles);
        logic [31:0] val, r1, r4;
        logic        ov, un, o1, u1, o4, u4;
        bit          resolved, g1, g4;
        int          shift_abs, cyc, c1, c4;
        model(f, fp, val, ov, un, resolved, shift_abs);
        @(negedge clk);
        check("in_ready1_idle", 64'(rdy1), 64'd1);
        check("in_ready4_idle", 64'(rdy4), 64'd1);
        float_in = f; fixpointpos = fp; in_valid = 1'b1; out_ready = hold_ready;
        @(negedge clk);
        in_valid = 1'b0; float_in = $urandom; fixpointpos = 5'($urandom);
        cyc = 1; g1 = 0; g4 = 0; c1 = 0; c4 = 0;
        r1 = '0; r4 = '0; o1 = 0; u1 = 0; o4 = 0; u4 = 0;
        while (!(g1 && g4) && cyc <= 40) begin
            if (!g1 && vld1) begin g1 = 1; c1 = cyc; r1 = fo1; o1 = of1; u1 = uf1; end
            if (!g4 && vld4) begin g4 = 1; c4 = cyc; r4 = fo4; o4 = of4; u4 = uf4; end
            if (!(g1 && g4)) begin @(negedge clk); cyc++; end
        end
        if (!(g1 && g4)) begin
            check("out_valid_timeout", {62'd0, g1, g4}, 64'd3);
            rst = 1'b0; @(negedge clk); rst = 1'b1; out_ready = 1'b0;
            return;
        end
        check("lat_step1", 64'(c1), 64'(lat_for(resolved, shift_abs, 1)));
        check("lat_step4", 64'(c4), 64'(lat_for(resolved, shift_abs, 4)));
        check("result1", {30'd0, o1, u1, r1}, {30'd0, ov, un, val});
        check("result4", {30'd0, o4, u4, r4}, {30'd0, ov, un, val});
        if (!hold_ready) begin
            for (int i = 0; i < bp_cycles; i++) begin
                in_valid = i[0]; float_in = $urandom;
                check("bp_hold1", {29'd0, vld1, rdy1, of1, uf1, fo1}, {29'd0, 1'b1, 1'b0, ov, un, val});
                check("bp_hold4", {29'd0, vld4, rdy4, of4, uf4, fo4}, {29'd0, 1'b1, 1'b0, ov, un, val});
                @(negedge clk);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("after_xfer1", {29'd0, vld1, rdy1, of1, uf1, fo1}, {29'd0, 1'b0, 1'b1, 1'b0, 1'b0, val});
        check("after_xfer4", {29'd0, vld4, rdy4, of4, uf4, fo4}, {29'd0, 1'b0, 1'b1, 1'b0, 1'b0, val});
    endtask

    logic [7:0]  re;
    logic [31:0] rf;

    initial begin
        #1;
        check("reset1", {29'd0, vld1, rdy1, of1, uf1, fo1}, {29'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        check("reset4", {29'd0, vld4, rdy4, of4, uf4, fo4}, {29'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b1;

        run_op(32'h40490FDB, 5'd16, 1'b0, 0);
        run_op(32'hC2F60000, 5'd4,  1'b0, 1);
        run_op(32'h4F000000, 5'd0,  1'b0, 0);
        run_op(32'hCF000000, 5'd0,  1'b0, 0);
        run_op(32'h7F800000, 5'd9,  1'b0, 0);
        run_op(32'hFF800000, 5'd0,  1'b0, 0);
        run_op(32'h7FC00000, 5'd3,  1'b0, 0);
        run_op(32'hFFC00001, 5'd3,  1'b0, 0);
        run_op(32'h00000000, 5'd7,  1'b0, 0);
        run_op(32'h80000000, 5'd0,  1'b0, 0);
        run_op(32'h00400000, 5'd31, 1'b0, 0);
        run_op(32'h3F000000, 5'd0,  1'b0, 0);
        run_op(32'h3F800000, 5'd23, 1'b1, 0);
        run_op(32'hBF800000, 5'd31, 1'b0, 0);
        run_op(32'h3F800000, 5'd31, 1'b0, 0);
        run_op(32'h40490FDB, 5'd16, 1'b0, 5);
        run_op(32'hC2F60000, 5'd4,  1'b1, 0);

        // Reset in the middle of a long right shift.
        @(negedge clk);
        float_in = 32'h3F800000; fixpointpos = 5'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midshift_rst1", {29'd0, vld1, rdy1, of1, uf1, fo1}, {29'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        check("midshift_rst4", {29'd0, vld4, rdy4, of4, uf4, fo4}, {29'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b1;
        run_op(32'hC2F60000, 5'd4, 1'b0, 0);

        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 9))
                0:       re = 8'h00;
                1:       re = 8'hFF;
                default: re = 8'($urandom_range(90, 165));
            endcase
            rf = {1'($urandom), re, ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom)};
            run_op(rf, 5'($urandom), 1'($urandom), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "simulation time limit");
    end

endmodule
